// File: rtl/adc_pkg.sv
// Shared types and constants for the ADC frame collector: state encoding,
// frame geometry and sample/channel widths.
package adc_pkg;

    localparam int NUM_CH   = 6;
    localparam int SAMPLE_W = 16;
    localparam int CH_W     = 3;

    typedef logic [SAMPLE_W-1:0] sample_t;
    typedef logic [CH_W-1:0]     chan_t;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_COLLECT = 2'd2,
        ST_STREAM  = 2'd3
    } state_t;

    // Channel number carried by the final word of an n-channel frame.
    function automatic chan_t last_chan(input int n);
        return chan_t'(n - 1);
    endfunction

endpackage

// File: rtl/adc_frame_collector_if.sv
// Frame output stream: one word per transfer, valid/ready handshake,
// out_last marks the final channel of a frame.
interface adc_frame_collector_if;
    import adc_pkg::*;

    sample_t out_data;
    chan_t   out_ch;
    logic    out_valid;
    logic    out_last;
    logic    out_ready;

    modport master (
        output out_data,
        output out_ch,
        output out_valid,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_data,
        input  out_ch,
        input  out_valid,
        input  out_last,
        output out_ready
    );

endinterface

// File: rtl/sat_cnt8.sv
// 8-bit event counter that sticks at 255 instead of wrapping.
module sat_cnt8 (
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    output logic [7:0] cnt
);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= 8'd0;
        end else if (inc && (cnt != 8'hFF)) begin
            cnt <= cnt + 8'd1;
        end
    end

endmodule

// File: rtl/adc_frame_collector.sv
// Periodically requests an ADC capture, gathers one sample per channel in
// order, and replays the completed frame on a valid/ready stream.
module adc_frame_collector
    import adc_pkg::*;
#(
    parameter int SYNC_PERIOD = 2048,
    parameter int TIMEOUT     = 1024,
    parameter int NUM_CH      = adc_pkg::NUM_CH
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         OP_MODE,
    input  logic                         RD_EN,
    input  sample_t                      DATA_I,
    input  chan_t                        CHANNEL_I,
    output logic                         SYNC,
    adc_frame_collector_if.master        stream,
    output logic [15:0]                  frame_cnt,
    output logic [7:0]                   err_cnt,
    output logic [7:0]                   skip_cnt
);

    localparam int    PER_W   = (SYNC_PERIOD > 1) ? $clog2(SYNC_PERIOD) : 1;
    localparam int    TMO_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam chan_t LAST_CH = last_chan(NUM_CH);

    state_t           state;
    state_t           next_state;
    logic [PER_W-1:0] per_cnt;
    logic [PER_W-1:0] per_next;
    logic [TMO_W-1:0] tmo_cnt;
    chan_t            idx;
    chan_t            widx;
    chan_t            widx_inc;
    sample_t          frame_buf [NUM_CH];

    logic period_hit;
    logic sync_req;
    logic store_en;
    logic order_err;
    logic tmo_err;
    logic word_xfer;
    logic frame_done;
    logic start_stream;
    logic skip_inc;
    logic err_inc;

    // Dropping OP_MODE overrides everything: the frame in flight is abandoned
    // without being counted as an error.
    always_comb begin
        next_state   = state;
        sync_req     = 1'b0;
        store_en     = 1'b0;
        order_err    = 1'b0;
        tmo_err      = 1'b0;
        frame_done   = 1'b0;
        start_stream = 1'b0;
        skip_inc     = 1'b0;
        period_hit   = (state != ST_IDLE) && (per_cnt == PER_W'(SYNC_PERIOD - 1));
        word_xfer    = (state == ST_STREAM) && stream.out_valid && stream.out_ready;

        if (!OP_MODE) begin
            next_state = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    next_state = ST_WAIT;
                end
                ST_WAIT: begin
                    if (period_hit) begin
                        sync_req   = 1'b1;
                        next_state = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    skip_inc = period_hit;
                    if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
                        tmo_err    = 1'b1;
                        next_state = ST_WAIT;
                    end else if (RD_EN) begin
                        if (CHANNEL_I == idx) begin
                            store_en = 1'b1;
                            if (idx == LAST_CH) begin
                                start_stream = 1'b1;
                                next_state   = ST_STREAM;
                            end
                        end else begin
                            order_err  = 1'b1;
                            next_state = ST_WAIT;
                        end
                    end
                end
                ST_STREAM: begin
                    skip_inc = period_hit;
                    if (word_xfer && (widx == LAST_CH)) begin
                        frame_done = 1'b1;
                        next_state = ST_WAIT;
                    end
                end
                default: begin
                    next_state = ST_IDLE;
                end
            endcase
        end

        if ((state == ST_IDLE) || (next_state == ST_IDLE) || period_hit) begin
            per_next = '0;
        end else begin
            per_next = per_cnt + PER_W'(1);
        end
    end

    assign err_inc  = order_err | tmo_err;
    assign widx_inc = widx + chan_t'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // SYNC is computed one cycle ahead so the flop is high exactly during the
    // WAIT cycle whose period count is the last one of the period.
    always_ff @(posedge clk) begin
        if (rst) begin
            per_cnt <= '0;
            SYNC    <= 1'b0;
        end else begin
            per_cnt <= per_next;
            SYNC    <= (next_state == ST_WAIT) && (per_next == PER_W'(SYNC_PERIOD - 1));
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tmo_cnt <= '0;
            idx     <= '0;
        end else if (sync_req) begin
            tmo_cnt <= '0;
            idx     <= '0;
        end else if (state == ST_COLLECT) begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
            if (store_en) begin
                idx <= idx + chan_t'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (store_en) begin
            frame_buf[idx] <= DATA_I;
        end
    end

    // Word 0 is already buffered when the last sample arrives, so the stream
    // can present it on the very first STREAM cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
            stream.out_data  <= '0;
            stream.out_ch    <= '0;
            widx             <= '0;
            frame_cnt        <= 16'd0;
        end else if (!OP_MODE) begin
            stream.out_valid <= 1'b0;
            stream.out_last  <= 1'b0;
        end else if (start_stream) begin
            stream.out_valid <= 1'b1;
            stream.out_data  <= frame_buf[0];
            stream.out_ch    <= '0;
            stream.out_last  <= (LAST_CH == chan_t'(0));
            widx             <= '0;
        end else if (word_xfer) begin
            if (frame_done) begin
                stream.out_valid <= 1'b0;
                stream.out_last  <= 1'b0;
                frame_cnt        <= frame_cnt + 16'd1;
            end else begin
                widx            <= widx_inc;
                stream.out_data <= frame_buf[widx_inc];
                stream.out_ch   <= widx_inc;
                stream.out_last <= (widx_inc == LAST_CH);
            end
        end
    end

    sat_cnt8 u_err_cnt (
        .clk (clk),
        .rst (rst),
        .inc (err_inc),
        .cnt (err_cnt)
    );

    sat_cnt8 u_skip_cnt (
        .clk (clk),
        .rst (rst),
        .inc (skip_inc),
        .cnt (skip_cnt)
    );

endmodule

// File: tb/tb_adc_frame_collector.sv
// Directed bench for adc_frame_collector with a 64-cycle sync period and a
// 32-cycle collection timeout.
module tb_adc_frame_collector;
    import adc_pkg::*;

    logic        clk;
    logic        rst;
    logic        OP_MODE;
    logic        RD_EN;
    sample_t     DATA_I;
    chan_t       CHANNEL_I;
    logic        SYNC;
    logic [15:0] frame_cnt;
    logic [7:0]  err_cnt;
    logic [7:0]  skip_cnt;

    int check_count;
    int error_count;
    int cyc;
    int last_sync;

    adc_frame_collector_if sif ();

    adc_frame_collector #(
        .SYNC_PERIOD (64),
        .TIMEOUT     (32),
        .NUM_CH      (6)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .OP_MODE   (OP_MODE),
        .RD_EN     (RD_EN),
        .DATA_I    (DATA_I),
        .CHANNEL_I (CHANNEL_I),
        .SYNC      (SYNC),
        .stream    (sif.master),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt),
        .skip_cnt  (skip_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            error_count++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic applyStimulus(input chan_t ch, input sample_t data);
        RD_EN     = 1'b1;
        CHANNEL_I = ch;
        DATA_I    = data;
        tick();
        RD_EN     = 1'b0;
    endtask

    // Returns with cyc pointing at the cycle SYNC is high; reports the gap
    // since the previous reference point held in last_sync.
    task automatic wait_sync(output int gap);
        int n;
        n = 0;
        while (!SYNC && n < 300) begin
            tick();
            n++;
        end
        if (!SYNC) begin
            checkOutput("sync_timeout", 32'd0, 32'd1);
        end
        gap       = cyc - last_sync;
        last_sync = cyc;
    endtask

    task automatic send_frame(input sample_t base);
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 6; i++) applyStimulus(chan_t'(i), base + sample_t'(i));
    endtask

    task automatic recv_frame(input sample_t base);
        int w;
        for (int i = 0; i < 6; i++) begin
            w = 0;
            while (!sif.out_valid && w < 50) begin
                tick();
                w++;
            end
            checkOutput("word_data", 32'(sif.out_data), 32'(base + sample_t'(i)));
            checkOutput("word_ch", 32'(sif.out_ch), i);
            checkOutput("word_last", 32'(sif.out_last), (i == 5) ? 32'd1 : 32'd0);
            if (i > 0) checkOutput("word_gap", w, 0);
            tick();
        end
        checkOutput("valid_after_frame", 32'(sif.out_valid), 32'd0);
    endtask

    initial begin
        int gap;
        int frozen_bad;
        int sync_seen;

        check_count   = 0;
        error_count   = 0;
        cyc           = 0;
        last_sync     = 0;
        rst           = 1'b1;
        OP_MODE       = 1'b0;
        RD_EN         = 1'b0;
        DATA_I        = '0;
        CHANNEL_I     = '0;
        sif.out_ready = 1'b1;

        tick();
        tick();
        rst = 1'b0;
        tick();
        checkOutput("rst_sync", 32'(SYNC), 32'd0);
        checkOutput("rst_valid", 32'(sif.out_valid), 32'd0);
        checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("rst_skip_cnt", 32'(skip_cnt), 32'd0);

        // Nominal frame: first SYNC 64 cycles after OP_MODE rises.
        $display("[TB] nominal frame");
        OP_MODE   = 1'b1;
        last_sync = cyc;
        wait_sync(gap);
        checkOutput("first_sync_gap", gap, 64);
        tick();
        checkOutput("sync_one_cycle", 32'(SYNC), 32'd0);
        for (int i = 0; i < 4; i++) tick();
        for (int i = 0; i < 6; i++) applyStimulus(chan_t'(i), 16'h1000 + sample_t'(i));
        recv_frame(16'h1000);
        checkOutput("frame_cnt_1", 32'(frame_cnt), 32'd1);
        wait_sync(gap);
        checkOutput("sync_period", gap, 64);

        // Channel order error.
        $display("[TB] order error");
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(3'd0, 16'hAAAA);
        applyStimulus(3'd2, 16'hBBBB);
        checkOutput("order_err_cnt", 32'(err_cnt), 32'd1);
        checkOutput("order_no_word", 32'(sif.out_valid), 32'd0);
        wait_sync(gap);
        checkOutput("order_sync_gap", gap, 64);

        // Timeout: COLLECT starts the cycle after SYNC, drop registers at S+33.
        $display("[TB] timeout");
        for (int i = 0; i < 5; i++) tick();
        for (int i = 0; i < 3; i++) applyStimulus(chan_t'(i), 16'h1100 + sample_t'(i));
        while (cyc < last_sync + 32) tick();
        checkOutput("tmo_before", 32'(err_cnt), 32'd1);
        tick();
        checkOutput("tmo_after", 32'(err_cnt), 32'd2);
        checkOutput("tmo_no_word", 32'(sif.out_valid), 32'd0);
        wait_sync(gap);
        checkOutput("tmo_sync_gap", gap, 64);

        // Backpressure across a period boundary.
        $display("[TB] backpressure");
        sif.out_ready = 1'b0;
        send_frame(16'h2000);
        frozen_bad = 0;
        for (int i = 0; i < 100; i++) begin
            if (!sif.out_valid || sif.out_data != 16'h2000 || sif.out_ch != 3'd0 || sif.out_last) frozen_bad++;
            tick();
        end
        checkOutput("bp_frozen", frozen_bad, 0);
        checkOutput("bp_skip_cnt", 32'(skip_cnt), 32'd1);
        sif.out_ready = 1'b1;
        recv_frame(16'h2000);
        checkOutput("frame_cnt_2", 32'(frame_cnt), 32'd2);
        wait_sync(gap);
        checkOutput("bp_sync_gap", gap, 128);

        // OP_MODE drop mid-collect.
        $display("[TB] op_mode drop");
        for (int i = 0; i < 5; i++) tick();
        applyStimulus(3'd0, 16'h3000);
        applyStimulus(3'd1, 16'h3001);
        OP_MODE   = 1'b0;
        sync_seen = 0;
        for (int i = 0; i < 150; i++) begin
            tick();
            if (SYNC) sync_seen++;
        end
        checkOutput("opm_no_sync", sync_seen, 0);
        checkOutput("opm_err_cnt", 32'(err_cnt), 32'd2);
        checkOutput("opm_valid", 32'(sif.out_valid), 32'd0);
        OP_MODE   = 1'b1;
        last_sync = cyc;
        wait_sync(gap);
        checkOutput("opm_resync_gap", gap, 64);

        // Error counter saturation.
        $display("[TB] err_cnt saturation");
        for (int k = 0; k < 300; k++) begin
            if (k > 0) wait_sync(gap);
            tick();
            applyStimulus(3'd1, 16'hDEAD);
        end
        checkOutput("err_saturated", 32'(err_cnt), 32'd255);

        // Reset in the middle of a stalled stream.
        $display("[TB] reset mid-stream");
        wait_sync(gap);
        sif.out_ready = 1'b0;
        send_frame(16'h4000);
        checkOutput("pre_rst_valid", 32'(sif.out_valid), 32'd1);
        rst = 1'b1;
        tick();
        checkOutput("post_rst_valid", 32'(sif.out_valid), 32'd0);
        checkOutput("post_rst_last", 32'(sif.out_last), 32'd0);
        checkOutput("post_rst_data", 32'(sif.out_data), 32'd0);
        checkOutput("post_rst_ch", 32'(sif.out_ch), 32'd0);
        checkOutput("post_rst_sync", 32'(SYNC), 32'd0);
        checkOutput("post_rst_frame_cnt", 32'(frame_cnt), 32'd0);
        checkOutput("post_rst_err_cnt", 32'(err_cnt), 32'd0);
        checkOutput("post_rst_skip_cnt", 32'(skip_cnt), 32'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule

// File: doc/adc_frame_collector.md
ADC_FRAME_COLLECTOR -- requirements
Module: adc_frame_collector

Interface
REQ-001 Parameter SYNC_PERIOD, default 2048, clk cycles between SYNC requests (min 16).
REQ-002 Parameter TIMEOUT, default 1024, max clk cycles allowed to collect one frame.
REQ-003 Parameter NUM_CH, default 6, channels per frame (fixed at 6 for this design).
REQ-004 Clocking: one clock, clk; reset rst, synchronous, active-high.
REQ-005 clk  in  1  system clock, same domain as adc733_wrap DATA_O/RD_EN.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 OP_MODE  in  1  1 = ADC in data mode; frames only requested while high.
REQ-008 RD_EN  in  1  one-cycle strobe, new sample valid on DATA_I/CHANNEL_I.
REQ-009 DATA_I  in  16  ADC sample.
REQ-010 CHANNEL_I  in  3  channel number of sample.
REQ-011 SYNC  out  1  one-cycle capture request to adc733_wrap.
REQ-012 out_data  out  16 ; out_ch  out  3 ; out_valid  out  1 ; out_last  out  1 ; out_ready  in  1  frame output stream.
REQ-013 frame_cnt  out  16  frames delivered, wraps at 65535->0.
REQ-014 err_cnt  out  8  dropped frames (order error or timeout), saturates at 255.
REQ-015 skip_cnt  out  8  SYNC periods skipped because busy, saturates at 255.

Function
REQ-016 States: IDLE, WAIT, COLLECT, STREAM.
REQ-017 IDLE: period counter held 0; go WAIT when OP_MODE=1.
REQ-018 Period counter increments every cycle outside IDLE, reloads to 0 on reaching SYNC_PERIOD-1.
REQ-019 WAIT and counter=SYNC_PERIOD-1: SYNC=1 for exactly that cycle (registered), next state COLLECT, channel index 0, timeout counter 0.
REQ-020 Counter=SYNC_PERIOD-1 in COLLECT or STREAM: no SYNC, skip_cnt+1.
REQ-021 COLLECT: RD_EN with CHANNEL_I == index stores DATA_I into buffer[index], index+1.
REQ-022 COLLECT: RD_EN with CHANNEL_I != index drops frame, err_cnt+1, next state WAIT.
REQ-023 COLLECT: timeout counter reaches TIMEOUT-1 without 6th sample -> drop, err_cnt+1, WAIT; RD_EN in that same cycle is ignored.
REQ-024 Storing index 5 -> STREAM next cycle; out_valid high first STREAM cycle with buffer[0], out_ch=0.
REQ-025 STREAM: word transfers when out_valid && out_ready; out_data/out_ch/out_last stable while out_valid && !out_ready.
REQ-026 out_last=1 only on channel 5 word; its transfer increments frame_cnt, deasserts out_valid next cycle, next state WAIT.
REQ-027 RD_EN outside COLLECT ignored, no counter change.
REQ-028 OP_MODE=0 in any state: next state IDLE, out_valid 0, partial frame discarded silently (no err_cnt).
REQ-029 SYNC never asserted while OP_MODE=0 or outside WAIT.
REQ-030 Continuous out_ready=1: 6 words on 6 consecutive cycles.

Reset
REQ-031 rst: state IDLE; SYNC, out_valid, out_last 0; out_data 0, out_ch 0; all counters 0; buffer contents don't-care.
REQ-032 rst mid-COLLECT or mid-STREAM: abort, no counter update; next cycle IDLE.

Structure
REQ-033 Shared package adc_pkg: state encoding, NUM_CH, sample width 16, channel width 3.
REQ-034 One sub-module sat_cnt8 (saturating 8-bit incrementer) instanced for err_cnt and skip_cnt; buffer is a 6x16 register array.

Verification
REQ-035 SYNC_PERIOD=64, OP_MODE=1, samples ch0..5 = 16'h1000..16'h1005 5 cycles after SYNC, out_ready=1 -> 6 words h1000..h1005, out_last on h1005, frame_cnt=1, SYNC every 64 cycles.
REQ-036 Order error: samples ch0, ch2 -> no output words, err_cnt=1, next SYNC on schedule.
REQ-037 TIMEOUT=32, only 3 samples -> err_cnt=1 at cycle 32 after SYNC, state WAIT.
REQ-038 out_ready held 0 for 100 cycles with SYNC_PERIOD=64 -> out_data frozen at word 0, skip_cnt=1, then all 6 words delivered on release.
REQ-039 OP_MODE dropped mid-COLLECT -> IDLE, no SYNC while low, err_cnt unchanged; raise again -> SYNC after 64 cycles.
REQ-040 300 order errors -> err_cnt saturates at 255; rst -> all outputs and counters 0.
